insertion_sort_p: RTL and testbench

Parametrised successor to the fixed 16-bit / 256-entry insertion-sort buffer. It holds up to 2**AW words of DW bits in an internal array and accepts toggle-encoded push, pop, clear and sort commands. It sorts the stored words in place with a stable insertion sort, ascending or descending, using signed or unsigned compare. It sits as a command-driven sorting scratchpad behind a host sequencer that talks to it only through level-toggle commands.

---
 rtl/insertion_sort_p.sv | 174 +++++++++++++++++
 tb/tb_insertion_sort_p.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/insertion_sort_p.sv
// Command-driven sorting scratchpad: LIFO push/pop storage that sorts
// itself in place with a stable insertion sort on a toggle command.
module insertion_sort_p #(
  parameter int DW     = 16,
  parameter int AW     = 8,
  parameter int SIGNED = 0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          enable,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic          sort,
  input  logic          descend,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          idle,
  output logic          done,
  output logic          err,
  output logic [3:0]    cst,
  output logic [3:0]    nst
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULLV = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE = (AW+1)'(1);

  typedef enum logic [3:0] {
    IDLE    = 4'b0000,
    CLEAR   = 4'b0001,
    PUSH    = 4'b0011,
    POP     = 4'b0010,
    J_INIT  = 4'b0110,
    J_JMP   = 4'b0111,
    I_INIT  = 4'b0101,
    I_JMP   = 4'b0100,
    I_SHIFT = 4'b1100,
    I_END   = 4'b1101,
    J_NEXT  = 4'b1111,
    J_END   = 4'b1110
  } state_e;

  state_e cst_q, nst_d;

  logic          push_q, pop_q, clear_q, sort_q;
  logic          desc_q, err_q;
  logic [DW-1:0] dout_q, key_q;
  logic [AW:0]   count_q, j_q, i_q;
  logic [DW-1:0] mem [DEPTH];

  logic          push_ev, pop_ev, clear_ev, sort_ev;
  logic [AW-1:0] top, ip1;
  logic [DW-1:0] a_i;
  logic          gt, lt, out_c;

  assign push_ev  = push ^ push_q;
  assign pop_ev   = pop ^ pop_q;
  assign clear_ev = clear ^ clear_q;
  assign sort_ev  = sort ^ sort_q;

  assign top = count_q[AW-1:0] - AW'(1);
  assign ip1 = i_q[AW-1:0] + AW'(1);
  assign a_i = mem[i_q[AW-1:0]];

  always_comb begin
    gt = 1'b0;
    lt = 1'b0;
    if (SIGNED != 0) begin
      gt = $signed(a_i) > $signed(key_q);
      lt = $signed(a_i) < $signed(key_q);
    end else begin
      gt = a_i > key_q;
      lt = a_i < key_q;
    end
    out_c = desc_q ? lt : gt;
  end

  always_comb begin
    nst_d = IDLE;
    case (cst_q)
      IDLE: begin
        if (clear_ev)     nst_d = CLEAR;
        else if (push_ev) nst_d = PUSH;
        else if (pop_ev)  nst_d = POP;
        else if (sort_ev) nst_d = J_INIT;
      end
      J_INIT:  nst_d = J_JMP;
      J_JMP:   nst_d = (j_q >= count_q) ? J_END : I_INIT;
      I_INIT:  nst_d = I_JMP;
      // i_q[AW] is the sign bit: the scan ran past slot 0
      I_JMP:   nst_d = (i_q[AW] || !out_c) ? I_END : I_SHIFT;
      I_SHIFT: nst_d = I_JMP;
      I_END:   nst_d = J_NEXT;
      J_NEXT:  nst_d = J_JMP;
      default: nst_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cst_q   <= IDLE;
      push_q  <= 1'b0;
      pop_q   <= 1'b0;
      clear_q <= 1'b0;
      sort_q  <= 1'b0;
      desc_q  <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= '0;
      key_q   <= '0;
      count_q <= '0;
      j_q     <= '0;
      i_q     <= '0;
    end else if (enable) begin
      cst_q   <= nst_d;
      push_q  <= push;
      pop_q   <= pop;
      clear_q <= clear;
      sort_q  <= sort;
      case (cst_q)
        CLEAR: begin
          count_q <= '0;
          err_q   <= 1'b0;
        end
        PUSH: begin
          if (full) err_q <= 1'b1;
          else      count_q <= count_q + ONE;
        end
        POP: begin
          if (empty) begin
            err_q <= 1'b1;
          end else begin
            dout_q  <= mem[top];
            count_q <= count_q - ONE;
          end
        end
        J_INIT: begin
          j_q    <= ONE;
          desc_q <= descend;
        end
        J_JMP:   key_q <= mem[j_q[AW-1:0]];
        I_INIT:  i_q <= j_q - ONE;
        I_SHIFT: i_q <= i_q - ONE;
        J_NEXT:  j_q <= j_q + ONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enable) begin
      case (cst_q)
        PUSH:    if (!full) mem[count_q[AW-1:0]] <= din;
        I_SHIFT: mem[ip1] <= a_i;
        I_END:   mem[ip1] <= key_q;
        default: ;
      endcase
    end
  end

  assign dout  = dout_q;
  assign count = count_q;
  assign full  = (count_q == FULLV);
  assign empty = (count_q == '0);
  assign idle  = (cst_q == IDLE);
  assign done  = (cst_q == J_END);
  assign err   = err_q;
  assign cst   = cst_q;
  assign nst   = nst_d;

endmodule

// File: tb/tb_insertion_sort_p.sv
// Bench for insertion_sort_p: a signed and an unsigned 4-deep, 8-bit
// instance share stimulus and are checked against a queue model.
module tb_insertion_sort_p;

  typedef logic [7:0] q8_t[$];

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       enable = 1'b1;
  logic       push = 1'b0, pop = 1'b0;
  logic       clear = 1'b0, sort = 1'b0;
  logic       descend = 1'b0;
  logic [7:0] din = '0;

  logic [7:0] dout_s, dout_u;
  logic [2:0] count_s, count_u;
  logic       full_s, empty_s, idle_s, done_s, err_s;
  logic       full_u, empty_u, idle_u, done_u, err_u;
  logic [3:0] cst_s, nst_s, cst_u, nst_u;

  int   nvec = 0;
  int   nmis = 0;
  bit   settled = 0;
  q8_t  qs, qu;
  logic [7:0] mds = '0, mdu = '0;
  bit   merr = 0;

  insertion_sort_p #(.DW(8), .AW(2), .SIGNED(1)) u_s (
    .clk(clk), .rstn(rstn), .enable(enable),
    .push(push), .pop(pop), .clear(clear), .sort(sort),
    .descend(descend), .din(din), .dout(dout_s),
    .count(count_s), .full(full_s), .empty(empty_s),
    .idle(idle_s), .done(done_s), .err(err_s),
    .cst(cst_s), .nst(nst_s)
  );

  insertion_sort_p #(.DW(8), .AW(2), .SIGNED(0)) u_u (
    .clk(clk), .rstn(rstn), .enable(enable),
    .push(push), .pop(pop), .clear(clear), .sort(sort),
    .descend(descend), .din(din), .dout(dout_u),
    .count(count_u), .full(full_u), .empty(empty_u),
    .idle(idle_u), .done(done_u), .err(err_u),
    .cst(cst_u), .nst(nst_u)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit outf(logic [7:0] a, logic [7:0] b,
                              bit sg, bit desc);
    int ka, kb;
    ka = sg ? int'($signed(a)) : int'(a);
    kb = sg ? int'($signed(b)) : int'(b);
    return desc ? (ka < kb) : (ka > kb);
  endfunction

  function automatic int slat(q8_t q, bit sg, bit desc);
    int s, l;
    s = 0;
    for (int a = 0; a < q.size(); a++)
      for (int b = a + 1; b < q.size(); b++)
        if (outf(q[a], q[b], sg, desc)) s++;
    l = 5 * q.size() - 2 + 2 * s;
    return (l < 3) ? 3 : l;
  endfunction

  // stable: always take the earliest element nobody must precede
  function automatic q8_t msort(q8_t q, bit sg, bit desc);
    q8_t r;
    int  m;
    bit  ok;
    while (q.size() > 0) begin
      m = 0;
      for (int a = q.size() - 1; a >= 0; a--) begin
        ok = 1;
        for (int b = 0; b < q.size(); b++)
          if (outf(q[a], q[b], sg, desc)) ok = 0;
        if (ok) m = a;
      end
      r.push_back(q[m]);
      q.delete(m);
    end
    return r;
  endfunction

  task automatic cmp(string t, logic [7:0] d, logic [2:0] c,
                     logic f, logic e, logic id, logic dn,
                     logic er, logic [3:0] ns, int n,
                     logic [7:0] md);
    check({t, ".count"}, c, n);
    check({t, ".empty"}, e, n == 0);
    check({t, ".full"}, f, n == 4);
    check({t, ".err"}, er, merr);
    check({t, ".idle"}, id, 1);
    check({t, ".done"}, dn, 0);
    check({t, ".dout"}, d, md);
    check({t, ".nst"}, ns, 0);
  endtask

  always @(negedge clk) begin
    if (settled && rstn) begin
      cmp("s", dout_s, count_s, full_s, empty_s, idle_s, done_s,
          err_s, nst_s, qs.size(), mds);
      cmp("u", dout_u, count_u, full_u, empty_u, idle_u, done_u,
          err_u, nst_u, qu.size(), mdu);
    end
  end

  task automatic chk_rst();
    check("rst.cst_s", cst_s, 0);
    check("rst.nst_s", nst_s, 0);
    check("rst.dout_s", dout_s, 0);
    check("rst.count_s", count_s, 0);
    check("rst.empty_s", empty_s, 1);
    check("rst.full_s", full_s, 0);
    check("rst.idle_s", idle_s, 1);
    check("rst.done_s", done_s, 0);
    check("rst.err_s", err_s, 0);
    check("rst.cst_u", cst_u, 0);
    check("rst.count_u", count_u, 0);
    check("rst.idle_u", idle_u, 1);
    check("rst.err_u", err_u, 0);
  endtask

  // kind: 0 clear, 1 push, 2 pop, 3 sort, 4 push+pop together
  task automatic do_cmd(int kind, logic [7:0] d, bit desc,
                        int lit_s, int lit_u, int gap_at,
                        int gap_len, int inj_at);
    int es, eu, xd, bs, bu, ds, du, k;
    es = 1; eu = 1; xd = 0;
    bs = 0; bu = 0; ds = 0; du = 0; k = 0;
    if (kind == 3) begin
      es = slat(qs, 1, desc) + gap_len;
      eu = slat(qu, 0, desc) + gap_len;
      xd = 1;
    end
    settled = 0;
    din = d;
    descend = desc;
    case (kind)
      0: clear = ~clear;
      1: push = ~push;
      2: pop = ~pop;
      3: sort = ~sort;
      default: begin push = ~push; pop = ~pop; end
    endcase
    @(posedge clk);
    do begin
      @(negedge clk);
      k++;
      if (k == gap_at) enable = 1'b0;
      if (gap_len > 0 && k == gap_at + gap_len) enable = 1'b1;
      if (k == inj_at) push = ~push;
      if (!idle_s) bs++;
      if (!idle_u) bu++;
      if (done_s) ds++;
      if (done_u) du++;
    end while ((!idle_s || !idle_u) && k < 2000);
    check("busy_timeout", idle_s & idle_u, 1);
    check("lat_s", bs, es);
    check("lat_u", bu, eu);
    if (lit_s >= 0) check("lat_s_lit", bs, lit_s);
    if (lit_u >= 0) check("lat_u_lit", bu, lit_u);
    check("done_s_pulses", ds, xd);
    check("done_u_pulses", du, xd);
    case (kind)
      0: begin qs.delete(); qu.delete(); merr = 0; end
      1, 4: begin
        if (qs.size() < 4) begin
          qs.push_back(d);
          qu.push_back(d);
        end else merr = 1;
      end
      2: begin
        if (qs.size() > 0) begin
          mds = qs.pop_back();
          mdu = qu.pop_back();
        end else merr = 1;
      end
      default: begin
        qs = msort(qs, 1, desc);
        qu = msort(qu, 0, desc);
      end
    endcase
    settled = 1;
  endtask

  task automatic p_push(logic [7:0] d);
    do_cmd(1, d, 0, 1, 1, 0, 0, 0);
  endtask

  task automatic p_pop();
    do_cmd(2, 8'h00, 0, 1, 1, 0, 0, 0);
  endtask

  task automatic p_clear();
    do_cmd(0, 8'h00, 0, 1, 1, 0, 0, 0);
  endtask

  task automatic p_sort(bit desc, int ls, int lu);
    do_cmd(3, 8'h00, desc, ls, lu, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk_rst();
    rstn = 1'b1;
    @(negedge clk);
    settled = 1;

    p_push(8'd3); p_push(8'd1); p_push(8'd2);
    p_sort(0, 17, 17);
    p_pop(); check("pop1_u", dout_u, 3);
    p_pop(); check("pop2_u", dout_u, 2);
    p_pop(); check("pop3_u", dout_u, 1);
    check("empty_after_pops", empty_u, 1);

    p_push(8'd5); p_push(8'd5); p_push(8'd4);
    p_sort(1, 13, 13);
    p_pop(); check("desc_pop_s", dout_s, 4);
    p_clear();
    p_push(8'd4); p_push(8'd5); p_push(8'd5);
    p_sort(1, 17, 17);
    p_pop(); check("desc2_pop_u", dout_u, 4);
    p_clear();

    p_push(8'h7F); p_push(8'h80); p_push(8'h00);
    p_sort(0, 17, 17);
    p_pop(); check("sg1", dout_s, 8'h7F); check("us1", dout_u, 8'h80);
    p_pop(); check("sg2", dout_s, 8'h00); check("us2", dout_u, 8'h7F);
    p_pop(); check("sg3", dout_s, 8'h80); check("us3", dout_u, 8'h00);

    p_clear();
    p_push(8'd1); p_push(8'd2); p_push(8'd3);
    check("not_full_3", full_s, 0);
    p_push(8'd4);
    check("full_4", full_s, 1);
    p_push(8'd5);
    check("err_overflow", err_s, 1);
    check("count_overflow", count_s, 4);
    p_clear();
    check("err_cleared", err_u, 0);
    p_pop();
    check("err_underflow", err_u, 1);
    check("dout_hold_s", dout_s, 8'h80);
    p_clear();
    check("err_cleared2", err_s, 0);

    p_push(8'd9);
    do_cmd(4, 8'd7, 0, 1, 1, 0, 0, 0);
    check("pushpop_count", count_s, 2);
    do_cmd(3, 8'h00, 0, 13, 13, 2, 3, 5);
    check("count_after_sort", count_u, 2);
    p_pop(); check("gap_pop1", dout_s, 9);
    p_pop(); check("gap_pop2", dout_s, 7);

    p_clear();
    p_push(8'd4); p_push(8'd3); p_push(8'd2); p_push(8'd1);
    settled = 0;
    descend = 1'b0;
    sort = ~sort;
    @(posedge clk);
    repeat (4) @(negedge clk);
    check("busy_before_rst", idle_s, 0);
    rstn = 1'b0;
    #1;
    chk_rst();
    push = 1'b0; pop = 1'b0; clear = 1'b0; sort = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    qs.delete(); qu.delete();
    mds = '0; mdu = '0; merr = 0;
    settled = 1;
    @(negedge clk);
    p_sort(0, 3, 3);
    check("count_after_rst_sort", count_s, 0);

    settled = 0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

endmodule
